// File: rtl/icache_dual_bank.sv
// Dual-bank (even/odd line) direct-mapped instruction cache with a
// single outstanding line-fill engine towards memory.
module icache_dual_bank #(
    parameter int XLEN    = 32,
    parameter int CL_SIZE = 128,
    parameter int SETS    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic [XLEN-1:0]    addr_even,
    input  logic [XLEN-1:0]    addr_odd,
    input  logic               flush,
    output logic               mem_hit_even,
    output logic               mem_hit_odd,
    output logic [CL_SIZE-1:0] cl_even,
    output logic [CL_SIZE-1:0] cl_odd,
    output logic [XLEN-1:0]    addr_out_even,
    output logic [XLEN-1:0]    addr_out_odd,
    output logic               is_write_even,
    output logic               is_write_odd,
    output logic               ic_stall,
    output logic               ic_exception,
    output logic               mem_req_valid,
    output logic [XLEN-1:0]    mem_req_addr,
    input  logic               mem_req_ready,
    input  logic               mem_resp_valid,
    input  logic [CL_SIZE-1:0] mem_resp_data
);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = XLEN - 5 - IDX_W;

    typedef enum logic [2:0] {IDLE, REQ_E, WAIT_E, REQ_O, WAIT_O, REPLAY, DRAIN} state_t;

    state_t               state_q, state_d;
    logic [SETS-1:0]      valid_e_q, valid_e_d, valid_o_q, valid_o_d;
    logic                 need_e_q, need_e_d, need_o_q, need_o_d;
    logic [XLEN-1:0]      lat_e_q, lat_e_d, lat_o_q, lat_o_d;
    logic                 hit_e_q, hit_e_d, hit_o_q, hit_o_d;
    logic [CL_SIZE-1:0]   cl_e_q, cl_e_d, cl_o_q, cl_o_d;
    logic [XLEN-1:0]      aout_e_q, aout_e_d, aout_o_q, aout_o_d;
    logic                 wr_e_q, wr_e_d, wr_o_q, wr_o_d;
    logic                 exc_q, exc_d;

    logic [TAG_W-1:0]     tag_e_mem [SETS];
    logic [TAG_W-1:0]     tag_o_mem [SETS];
    logic [CL_SIZE-1:0]   data_e_mem [SETS];
    logic [CL_SIZE-1:0]   data_o_mem [SETS];
    logic                 we_e, we_o;

    logic [XLEN-1:0]      rd_e, rd_o;
    logic [IDX_W-1:0]     rd_idx_e, rd_idx_o, lat_idx_e, lat_idx_o;
    logic                 look_hit_e, look_hit_o, bad_req;
    logic                 unused_addr_bits;

    assign unused_addr_bits = ^{addr_even[3:0], addr_odd[3:0]};

    // Arrays are read at the incoming addresses in IDLE and at the latched ones in REPLAY
    assign rd_e      = (state_q == REPLAY) ? lat_e_q : addr_even;
    assign rd_o      = (state_q == REPLAY) ? lat_o_q : addr_odd;
    assign rd_idx_e  = rd_e[4+IDX_W:5];
    assign rd_idx_o  = rd_o[4+IDX_W:5];
    assign lat_idx_e = lat_e_q[4+IDX_W:5];
    assign lat_idx_o = lat_o_q[4+IDX_W:5];

    assign look_hit_e = valid_e_q[rd_idx_e] && (tag_e_mem[rd_idx_e] == addr_even[XLEN-1:5+IDX_W]);
    assign look_hit_o = valid_o_q[rd_idx_o] && (tag_o_mem[rd_idx_o] == addr_odd[XLEN-1:5+IDX_W]);
    assign bad_req    = addr_even[4] || !addr_odd[4] || (addr_odd[XLEN-1:5] != addr_even[XLEN-1:5]);

    // Next-state, fill sequencing and registered-output computation
    always_comb begin
        state_d       = state_q;
        valid_e_d     = valid_e_q;
        valid_o_d     = valid_o_q;
        need_e_d      = need_e_q;
        need_o_d      = need_o_q;
        lat_e_d       = lat_e_q;
        lat_o_d       = lat_o_q;
        hit_e_d       = hit_e_q;
        hit_o_d       = hit_o_q;
        cl_e_d        = cl_e_q;
        cl_o_d        = cl_o_q;
        aout_e_d      = aout_e_q;
        aout_o_d      = aout_o_q;
        wr_e_d        = 1'b0;
        wr_o_d        = 1'b0;
        exc_d         = exc_q;
        we_e          = 1'b0;
        we_o          = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;

        if (flush) begin
            valid_e_d = '0;
            valid_o_d = '0;
            hit_e_d   = 1'b0;
            hit_o_d   = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!flush) begin
                    if (req_valid) begin
                        lat_e_d  = {addr_even[XLEN-1:4], 4'h0};
                        lat_o_d  = {addr_odd[XLEN-1:4], 4'h0};
                        aout_e_d = {addr_even[XLEN-1:4], 4'h0};
                        aout_o_d = {addr_odd[XLEN-1:4], 4'h0};
                        cl_e_d   = data_e_mem[rd_idx_e];
                        cl_o_d   = data_o_mem[rd_idx_o];
                        if (bad_req) begin
                            exc_d   = 1'b1;
                            hit_e_d = 1'b0;
                            hit_o_d = 1'b0;
                        end else begin
                            exc_d    = 1'b0;
                            hit_e_d  = look_hit_e;
                            hit_o_d  = look_hit_o;
                            need_e_d = !look_hit_e;
                            need_o_d = !look_hit_o;
                            if (!look_hit_e)      state_d = REQ_E;
                            else if (!look_hit_o) state_d = REQ_O;
                        end
                    end else begin
                        hit_e_d = 1'b0;
                        hit_o_d = 1'b0;
                    end
                end
            end
            REQ_E, REQ_O: begin
                // A flush withdraws the request in the same cycle so no handshake can complete
                mem_req_valid = !flush;
                mem_req_addr  = (state_q == REQ_E) ? lat_e_q : lat_o_q;
                if (flush)              state_d = IDLE;
                else if (mem_req_ready) state_d = (state_q == REQ_E) ? WAIT_E : WAIT_O;
            end
            WAIT_E, WAIT_O: begin
                // A beat coinciding with flush is dropped here; otherwise DRAIN absorbs the next one
                if (flush) begin
                    state_d = mem_resp_valid ? IDLE : DRAIN;
                end else if (mem_resp_valid) begin
                    if (state_q == WAIT_E) begin
                        we_e                 = 1'b1;
                        valid_e_d[lat_idx_e] = 1'b1;
                        state_d              = need_o_q ? REQ_O : REPLAY;
                    end else begin
                        we_o                 = 1'b1;
                        valid_o_d[lat_idx_o] = 1'b1;
                        state_d              = REPLAY;
                    end
                end
            end
            REPLAY: begin
                state_d = IDLE;
                if (!flush) begin
                    hit_e_d  = 1'b1;
                    hit_o_d  = 1'b1;
                    cl_e_d   = data_e_mem[rd_idx_e];
                    cl_o_d   = data_o_mem[rd_idx_o];
                    aout_e_d = lat_e_q;
                    aout_o_d = lat_o_q;
                    wr_e_d   = need_e_q;
                    wr_o_d   = need_o_q;
                end
            end
            DRAIN: begin
                if (mem_resp_valid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state, valid bits and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            valid_e_q <= '0;
            valid_o_q <= '0;
            need_e_q  <= 1'b0;
            need_o_q  <= 1'b0;
            lat_e_q   <= '0;
            lat_o_q   <= '0;
            hit_e_q   <= 1'b0;
            hit_o_q   <= 1'b0;
            cl_e_q    <= '0;
            cl_o_q    <= '0;
            aout_e_q  <= '0;
            aout_o_q  <= '0;
            wr_e_q    <= 1'b0;
            wr_o_q    <= 1'b0;
            exc_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            valid_e_q <= valid_e_d;
            valid_o_q <= valid_o_d;
            need_e_q  <= need_e_d;
            need_o_q  <= need_o_d;
            lat_e_q   <= lat_e_d;
            lat_o_q   <= lat_o_d;
            hit_e_q   <= hit_e_d;
            hit_o_q   <= hit_o_d;
            cl_e_q    <= cl_e_d;
            cl_o_q    <= cl_o_d;
            aout_e_q  <= aout_e_d;
            aout_o_q  <= aout_o_d;
            wr_e_q    <= wr_e_d;
            wr_o_q    <= wr_o_d;
            exc_q     <= exc_d;
        end
    end

    // Tag and data arrays, written only by accepted fill beats
    always_ff @(posedge clk) begin
        if (we_e) begin
            tag_e_mem[lat_idx_e]  <= lat_e_q[XLEN-1:5+IDX_W];
            data_e_mem[lat_idx_e] <= mem_resp_data;
        end
        if (we_o) begin
            tag_o_mem[lat_idx_o]  <= lat_o_q[XLEN-1:5+IDX_W];
            data_o_mem[lat_idx_o] <= mem_resp_data;
        end
    end

    assign mem_hit_even  = hit_e_q;
    assign mem_hit_odd   = hit_o_q;
    assign cl_even       = cl_e_q;
    assign cl_odd        = cl_o_q;
    assign addr_out_even = aout_e_q;
    assign addr_out_odd  = aout_o_q;
    assign is_write_even = wr_e_q;
    assign is_write_odd  = wr_o_q;
    assign ic_exception  = exc_q;
    assign ic_stall      = (state_q != IDLE);

endmodule

// File: tb/tb_icache_dual_bank.sv
// Randomized self-checking bench for icache_dual_bank against a
// line-level reference model of both banks.
module tb_icache_dual_bank;
    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid, flush;
    logic [31:0]  addr_even, addr_odd;
    logic         mem_hit_even, mem_hit_odd;
    logic [127:0] cl_even, cl_odd;
    logic [31:0]  addr_out_even, addr_out_odd;
    logic         is_write_even, is_write_odd;
    logic         ic_stall, ic_exception;
    logic         mem_req_valid;
    logic [31:0]  mem_req_addr;
    logic         mem_req_ready, mem_resp_valid;
    logic [127:0] mem_resp_data;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: per-bank, per-set valid/tag/line
    bit           mv_e [16];
    bit           mv_o [16];
    logic [22:0]  mt_e [16];
    logic [22:0]  mt_o [16];
    logic [127:0] md_e [16];
    logic [127:0] md_o [16];

    icache_dual_bank #(.XLEN(32), .CL_SIZE(128), .SETS(16)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid),
        .addr_even(addr_even), .addr_odd(addr_odd), .flush(flush),
        .mem_hit_even(mem_hit_even), .mem_hit_odd(mem_hit_odd),
        .cl_even(cl_even), .cl_odd(cl_odd),
        .addr_out_even(addr_out_even), .addr_out_odd(addr_out_odd),
        .is_write_even(is_write_even), .is_write_odd(is_write_odd),
        .ic_stall(ic_stall), .ic_exception(ic_exception),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
        .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            mv_e[i] = 1'b0;
            mv_o[i] = 1'b0;
        end
    endtask

    function automatic logic [127:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Memory side of one fill: hold ready low (hold cycles, or random when hold<0), then return data
    task automatic serve(input logic [31:0] exp_addr, input logic [127:0] data, input int hold);
        int  n;
        bit  rdy;
        n = 0;
        rdy = 1'b0;
        while (!rdy) begin
            check("mreq_valid", mem_req_valid, 1);
            check("mreq_addr", mem_req_addr, exp_addr);
            if (hold >= 0) rdy = (n >= hold);
            else           rdy = ($urandom_range(0, 2) == 0) || (n > 8);
            mem_req_ready = rdy;
            @(negedge clk);
            n++;
        end
        mem_req_ready = 1'b0;
        check("mreq_valid_wait", mem_req_valid, 0);
        check("stall_wait", ic_stall, 1);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        mem_resp_valid = 1'b1;
        mem_resp_data  = data;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
    endtask

    // One fetch request, including any fills and the replay, checked against the model
    task automatic fetch(input logic [31:0] ae, input logic [31:0] ao,
                         input logic [127:0] d_e, input logic [127:0] d_o, input int hold);
        logic [31:0] le, lo;
        int          ie, io;
        bit          bad, he, ho;
        le  = {ae[31:4], 4'h0};
        lo  = {ao[31:4], 4'h0};
        ie  = int'(ae[8:5]);
        io  = int'(ao[8:5]);
        bad = (ae[4] != 1'b0) || (ao[4] != 1'b1) || (ae[31:5] != ao[31:5]);
        he  = mv_e[ie] && (mt_e[ie] == ae[31:9]);
        ho  = mv_o[io] && (mt_o[io] == ao[31:9]);

        req_valid = 1'b1;
        addr_even = ae;
        addr_odd  = ao;
        @(negedge clk);
        req_valid = 1'b0;

        if (bad) begin
            check("exc_set", ic_exception, 1);
            check("exc_hit_e", mem_hit_even, 0);
            check("exc_hit_o", mem_hit_odd, 0);
            check("exc_stall", ic_stall, 0);
            check("exc_mreq", mem_req_valid, 0);
            return;
        end

        check("exc_clr", ic_exception, 0);
        check("hit_e", mem_hit_even, he);
        check("hit_o", mem_hit_odd, ho);
        check("stall", ic_stall, !(he && ho));
        check("aout_e", addr_out_even, le);
        check("aout_o", addr_out_odd, lo);
        if (he) check("cl_e_hit", cl_even, md_e[ie]);
        if (ho) check("cl_o_hit", cl_odd, md_o[io]);
        if (he && ho) begin
            check("wr_e_hit", is_write_even, 0);
            check("wr_o_hit", is_write_odd, 0);
            check("mreq_hit", mem_req_valid, 0);
            return;
        end

        if (!he) begin
            serve(le, d_e, hold);
            mv_e[ie] = 1'b1; mt_e[ie] = ae[31:9]; md_e[ie] = d_e;
        end
        if (!ho) begin
            serve(lo, d_o, hold);
            mv_o[io] = 1'b1; mt_o[io] = ao[31:9]; md_o[io] = d_o;
        end
        check("stall_replay", ic_stall, 1);
        @(negedge clk);
        check("rp_hit_e", mem_hit_even, 1);
        check("rp_hit_o", mem_hit_odd, 1);
        check("rp_cl_e", cl_even, md_e[ie]);
        check("rp_cl_o", cl_odd, md_o[io]);
        check("rp_aout_e", addr_out_even, le);
        check("rp_aout_o", addr_out_odd, lo);
        check("rp_wr_e", is_write_even, !he);
        check("rp_wr_o", is_write_odd, !ho);
        check("rp_stall", ic_stall, 0);
    endtask

    initial begin
        logic [31:0] base, ae, ao;
        int          r;

        rst = 1'b1; req_valid = 1'b0; flush = 1'b0;
        addr_even = '0; addr_odd = '0;
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
        model_clear();
        repeat (2) @(negedge clk);
        check("rst_stall", ic_stall, 0);
        check("rst_hit_e", mem_hit_even, 0);
        check("rst_hit_o", mem_hit_odd, 0);
        check("rst_exc", ic_exception, 0);
        check("rst_mreq", mem_req_valid, 0);
        check("rst_cl_e", cl_even, 0);
        rst = 1'b0;
        @(negedge clk);

        // Cold miss in both banks, then repeat hit
        fetch(32'h100, 32'h110, {4{32'hAAAA_AAAA}}, {4{32'hBBBB_BBBB}}, 0);
        fetch(32'h100, 32'h110, '0, '0, 0);
        @(negedge clk);
        check("idle_clr_e", mem_hit_even, 0);
        check("idle_clr_o", mem_hit_odd, 0);

        // Even-only conflict miss, misaligned request, backpressure
        fetch(32'h300, 32'h110, rnd_line(), rnd_line(), 1);
        fetch(32'h110, 32'h120, '0, '0, 0);
        fetch(32'h500, 32'h510, rnd_line(), rnd_line(), 5);

        // Flush while waiting for the even beat; the late beat must be discarded
        req_valid = 1'b1; addr_even = 32'h100; addr_odd = 32'h110;
        @(negedge clk);
        req_valid = 1'b0;
        check("fl_hit_e", mem_hit_even, 0);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        model_clear();
        check("fl_drain_stall", ic_stall, 1);
        check("fl_hit_o", mem_hit_odd, 0);
        mem_resp_valid = 1'b1; mem_resp_data = {4{32'hDEAD_BEEF}};
        @(negedge clk);
        mem_resp_valid = 1'b0;
        check("fl_idle", ic_stall, 0);
        fetch(32'h100, 32'h110, rnd_line(), rnd_line(), -1);

        // Asynchronous reset while waiting for the odd beat
        req_valid = 1'b1; addr_even = 32'h700; addr_odd = 32'h710;
        @(negedge clk);
        req_valid = 1'b0;
        serve(32'h700, rnd_line(), 0);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_stall", ic_stall, 0);
        check("arst_hit_e", mem_hit_even, 0);
        check("arst_hit_o", mem_hit_odd, 0);
        check("arst_mreq", mem_req_valid, 0);
        check("arst_cl_o", cl_odd, 0);
        #1 rst = 1'b0;
        model_clear();
        @(negedge clk);
        fetch(32'h700, 32'h710, rnd_line(), rnd_line(), -1);

        // Random traffic over a small address pool so hits, conflicts and errors all occur
        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(0, 9);
            base = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 3) << 5);
            ae = base | ($urandom & 32'hF);
            ao = base | 32'h10 | ($urandom & 32'hF);
            if (r == 0) begin
                flush = 1'b1; req_valid = 1'b1; addr_even = ae; addr_odd = ao;
                @(negedge clk);
                flush = 1'b0; req_valid = 1'b0;
                model_clear();
                check("rf_hit_e", mem_hit_even, 0);
                check("rf_hit_o", mem_hit_odd, 0);
                check("rf_stall", ic_stall, 0);
                check("rf_mreq", mem_req_valid, 0);
            end else begin
                if (r == 1) begin
                    case ($urandom_range(0, 2))
                        0:       ae = ae | 32'h10;
                        1:       ao = ao & ~32'h10;
                        default: ao = ao + 32'h20;
                    endcase
                end
                fetch(ae, ao, rnd_line(), rnd_line(), -1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time limit so a stuck design still ends the run
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/icache_dual_bank.md
Name: icache_dual_bank

Overview:
- Instruction cache responder for the frontend's split even/odd fetch interface.
- Accepts one even and one odd cache-line address per request and returns both lines with per-bank hit flags one cycle later.
- Misses stall the frontend via ic_stall while lines are filled from memory over a valid/ready request, single-beat response interface.
- Two direct-mapped banks: even lines have addr[4]=0, odd lines have addr[4]=1.

Parameters:
XLEN, 32, address width
CL_SIZE, 128, cache line size in bits (16 bytes; offset = addr[3:0])
SETS, 16, lines per bank (power of 2); index = addr[4+log2(SETS):5], tag = addr[XLEN-1:5+log2(SETS)]

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid  in  1  fetch request this cycle
addr_even  in  XLEN  even-line fetch address (from cache_addr_even)
addr_odd  in  XLEN  odd-line fetch address (from cache_addr_odd)
flush  in  1  invalidate all lines
mem_hit_even / mem_hit_odd  out  1  line valid and hit
cl_even / cl_odd  out  CL_SIZE  line data
addr_out_even / addr_out_odd  out  XLEN  line-aligned address of the returned line
is_write_even / is_write_odd  out  1  pulses 1 on the replay cycle after a fill of that bank
ic_stall  out  1  cache busy; new requests ignored
ic_exception  out  1  malformed request
mem_req_valid  out  1  line fill request
mem_req_addr  out  XLEN  line-aligned fill address, bits [3:0]=0
mem_req_ready  in  1  memory accepts request
mem_resp_valid  in  1  fill data beat
mem_resp_data  in  CL_SIZE  fill line

Behaviour:
- Reset (async, rst=1):
  - All outputs 0, all valid bits cleared, FSM in IDLE.
  - Data/tag arrays are not reset.
- FSM states: IDLE, REQ_E, WAIT_E, REQ_O, WAIT_O, REPLAY, DRAIN.
- ic_stall is combinational: 1 whenever state != IDLE.
- Lookup:
  - In IDLE with req_valid=1, at that edge both banks are indexed with the input addresses and results are registered.
  - hit/cl/addr_out are valid the next cycle (latency 1).
  - Addresses are latched for the fill.
- Hit outputs:
  - Each hit flag is registered and stays until the next accepted request, REPLAY, exception or flush.
  - A cycle with req_valid=0 in IDLE clears both hit flags.
- Exception check:
  - Condition: addr_even[4]!=0, or addr_odd[4]!=1, or addr_odd[XLEN-1:5] != addr_even[XLEN-1:5].
  - Response: ic_exception=1 next cycle, both hits 0, no fill, FSM stays IDLE. ic_exception clears on the next accepted request.
- Miss handling:
  - Miss in either bank gives IDLE -> REQ_E if even missed, else REQ_O.
  - The outputs for that cycle carry the real hit flags; at least one is 0.
- REQ_x:
  - mem_req_valid=1, mem_req_addr = latched line address; held stable until mem_req_ready=1.
  - Then -> WAIT_x.
- WAIT_x:
  - On mem_resp_valid: write data, tag and valid=1 into that bank.
  - WAIT_E -> REQ_O if odd also missed, else REPLAY. WAIT_O -> REPLAY.
- REPLAY:
  - Outputs re-registered from the arrays for the latched addresses; both hits=1.
  - is_write pulses for each filled bank.
  - -> IDLE.
  - Requests are accepted again on the cycle after REPLAY.
- req_valid while ic_stall=1 is ignored; the frontend holds its addresses.
- Flush:
  - Clears all valid bits at the edge and clears the hit outputs.
  - In IDLE / REQ_x / REPLAY: -> IDLE, and any pending mem_req is dropped (REQ_x has not yet handshaken).
  - In WAIT_x: -> DRAIN. DRAIN discards the next mem_resp_valid beat without writing, then -> IDLE.
  - Flush together with req_valid in IDLE: flush wins and the request is ignored.
- mem_resp_valid outside WAIT_x/DRAIN is ignored.
- Addresses on addr_out and mem_req_addr always have bits [3:0] forced to 0.

Test Plan:
- Cold miss, both banks:
  - Stimulus: reset, then req addr_even=0x100, addr_odd=0x110; memory returns 0xA..A then 0xB..B.
  - Response: next cycle hits 0/0 and ic_stall=1; mem_req 0x100 then 0x110; REPLAY hits 1/1 with cl_even=0xA..A, cl_odd=0xB..B; is_write 1/1; ic_stall=0 after.
- Repeat hit:
  - Stimulus: same request again.
  - Response: 1-cycle hits 1/1, same data, no mem_req, ic_stall stays 0.
- Even-only miss:
  - Stimulus: even 0x300 (conflicts with set of 0x100), odd 0x110 cached.
  - Response: hits 0/1; single mem_req 0x300; REPLAY hits 1/1; is_write_even=1, is_write_odd=0.
- Misaligned request:
  - Stimulus: addr_even=0x110, addr_odd=0x120.
  - Response: ic_exception=1 next cycle, hits 0/0, no mem_req_valid, ic_stall=0.
- Backpressure:
  - Stimulus: mem_req_ready held 0 for 5 cycles.
  - Response: mem_req_valid=1 and mem_req_addr stable for all 5; advances only on ready.
- Flush mid-fill:
  - Stimulus: flush in WAIT_E, then response beat arrives.
  - Response: beat is discarded, state returns to IDLE, and a re-request of 0x100 misses.
- Async reset mid-fill:
  - Stimulus: rst asserted between clock edges while in WAIT_O.
  - Response: outputs 0 immediately; a subsequent request misses in both banks.
